// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Fractional baud-rate divider producing a 1-cycle oversample
//               tick and a 1x bit tick, with shadowed runtime divisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_INT    = 27,
    parameter int DEF_FRAC   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_wr,
    input  logic              i_resync,
    output logic              o_os_tick,
    output logic              o_baud_tick,
    output logic              o_pending,
    output logic              o_cfg_err
);

    localparam int                c_OS_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_OS_W-1:0] c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  c_DEF_INT  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] c_DEF_FRAC = FRAC_W'(DEF_FRAC);
    localparam logic [DIV_W-1:0]  c_MIN_DIV  = DIV_W'(2);

    logic [DIV_W-1:0]  cnt_q,      cnt_d;
    logic [FRAC_W-1:0] facc_q,     facc_d;
    logic              long_q,     long_d;
    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  sh_int_q,   sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
    logic              pend_q,     pend_d;
    logic [c_OS_W-1:0] os_cnt_q,   os_cnt_d;
    logic              os_tick_q,  os_tick_d;
    logic              baud_q,     baud_d;
    logic              cfg_err_q,  cfg_err_d;

    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              w_term;
    logic [DIV_W-1:0]  w_term_cnt;
    logic [FRAC_W:0]   w_frac_sum;
    logic [DIV_W-1:0]  w_app_int;
    logic [FRAC_W-1:0] w_app_frac;

    assign w_wr_ok    = i_div_wr && (i_div_int >= c_MIN_DIV);
    assign w_wr_bad   = i_div_wr && (i_div_int <  c_MIN_DIV);
    assign w_term_cnt = act_int_q - DIV_W'(1) + DIV_W'(long_q);
    assign w_term     = i_en && (cnt_q == w_term_cnt);
    assign w_frac_sum = {1'b0, facc_q} + {1'b0, act_frac_q};
    // A write landing on the apply edge wins over the older shadow contents.
    assign w_app_int  = w_wr_ok ? i_div_int  : sh_int_q;
    assign w_app_frac = w_wr_ok ? i_div_frac : sh_frac_q;

    always_comb begin
        cnt_d      = cnt_q;
        facc_d     = facc_q;
        long_d     = long_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        baud_d     = 1'b0;
        cfg_err_d  = w_wr_bad;

        if (w_wr_ok) begin
            sh_int_d  = i_div_int;
            sh_frac_d = i_div_frac;
            pend_d    = 1'b1;
        end

        if (i_resync) begin
            cnt_d    = '0;
            facc_d   = '0;
            long_d   = 1'b0;
            os_cnt_d = '0;
        end else if (!i_en) begin
            if (pend_q) begin
                act_int_d  = w_app_int;
                act_frac_d = w_app_frac;
                pend_d     = 1'b0;
                cnt_d      = '0;
                facc_d     = '0;
                long_d     = 1'b0;
                os_cnt_d   = '0;
            end
        end else if (w_term) begin
            cnt_d     = '0;
            os_tick_d = 1'b1;
            baud_d    = (os_cnt_q == c_OS_LAST);
            os_cnt_d  = os_cnt_q + c_OS_W'(1);
            if (pend_q || w_wr_ok) begin
                act_int_d  = w_app_int;
                act_frac_d = w_app_frac;
                pend_d     = 1'b0;
                facc_d     = '0;
                long_d     = 1'b0;
            end else begin
                facc_d = w_frac_sum[FRAC_W-1:0];
                long_d = w_frac_sum[FRAC_W];
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            facc_q     <= '0;
            long_q     <= 1'b0;
            act_int_q  <= c_DEF_INT;
            act_frac_q <= c_DEF_FRAC;
            sh_int_q   <= c_DEF_INT;
            sh_frac_q  <= c_DEF_FRAC;
            pend_q     <= 1'b0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            baud_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            facc_q     <= facc_d;
            long_q     <= long_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            baud_q     <= baud_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_os_tick   = os_tick_q;
    assign o_baud_tick = baud_q;
    assign o_pending   = pend_q;
    assign o_cfg_err   = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
// ============================================================================
// Module      : tb_baud_tick_gen
// Description : Scoreboard bench for baud_tick_gen; expected tick times are
//               queued by the stimulus and consumed by a tick monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_tick_gen;

    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OVERSAMPLE = 16;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              en       = 1'b0;
    logic [DIV_W-1:0]  div_int  = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_wr   = 1'b0;
    logic              resync   = 1'b0;
    logic              os_tick;
    logic              baud_tick;
    logic              pending;
    logic              cfg_err;

    baud_tick_gen #(
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W),
        .OVERSAMPLE (OVERSAMPLE),
        .DEF_INT    (4),
        .DEF_FRAC   (0)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_div_int   (div_int),
        .i_div_frac  (div_frac),
        .i_div_wr    (div_wr),
        .i_resync    (resync),
        .o_os_tick   (os_tick),
        .o_baud_tick (baud_tick),
        .o_pending   (pending),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; a tick launched at edge N is seen at cyc == N.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int t;
        bit b;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input int t, input bit b);
        exp_t e;
        e.t = t;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input int start, input int period, input int n, input int idx0);
        for (int i = 0; i < n; i++)
            push(start + i * period, ((idx0 + i) % OVERSAMPLE) == (OVERSAMPLE - 1));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_os_tick: none at cyc %0d, expected one", e.t);
            end
            if (os_tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_os_tick at cyc %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cyc || e.b != baud_tick) begin
                        errors++;
                        $display("FAIL os_tick: got cyc %0d baud %0d, expected cyc %0d baud %0d",
                                 cyc, baud_tick, e.t, e.b);
                    end
                end
            end else if (baud_tick) begin
                checks++;
                errors++;
                $display("FAIL lone_baud_tick at cyc %0d: got 1, expected 0", cyc);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #2;
        check("rst_os_tick", os_tick, 0);
        check("rst_baud_tick", baud_tick, 0);
        check("rst_pending", pending, 0);
        check("rst_cfg_err", cfg_err, 0);

        // Default divisor 4: os tick every 4 cycles, baud on the 16th.
        @(negedge clk);
        push_run(4, 4, 16, 0);
        rst = 1'b0;
        en  = 1'b1;
        wait_cyc(64);

        // Fractional 4 + 8/16, written together with a resync.
        resync = 1'b1; div_wr = 1'b1; div_int = 16'd4; div_frac = 4'd8;
        push(69, 0);  push(73, 0);  push(77, 0);  push(82, 0);
        push(86, 0);  push(91, 0);  push(95, 0);  push(100, 0);
        push(104, 0); push(109, 0); push(113, 0); push(118, 0);
        push(122, 0); push(127, 0); push(131, 0); push(136, 1);
        push(140, 0); push(145, 0);
        @(negedge clk);
        resync = 1'b0; div_wr = 1'b0;
        check("pend_after_wr", pending, 1);
        wait_cyc(68);
        check("pend_before_apply", pending, 1);
        wait_cyc(69);
        check("pend_after_apply", pending, 0);
        wait_cyc(145);

        // Divisor 10, then a write of 6 while cnt == 3.
        resync = 1'b1; div_wr = 1'b1; div_int = 16'd10; div_frac = 4'd0;
        push(150, 0); push(160, 0); push(166, 0); push(172, 0); push(178, 0);
        @(negedge clk);
        resync = 1'b0; div_wr = 1'b0;
        wait_cyc(153);
        div_wr = 1'b1; div_int = 16'd6;
        @(negedge clk);
        div_wr = 1'b0;
        check("mid_wr_pend", pending, 1);
        wait_cyc(159);
        check("mid_wr_pend_hold", pending, 1);
        wait_cyc(160);
        check("mid_wr_pend_clear", pending, 0);
        wait_cyc(178);

        // Divisor 8, rejected write, then resync at cnt == 5.
        resync = 1'b1; div_wr = 1'b1; div_int = 16'd8;
        push_run(185, 8, 4, 0);
        push_run(223, 8, 16, 0);
        @(negedge clk);
        resync = 1'b0; div_wr = 1'b0;
        wait_cyc(193);
        div_wr = 1'b1; div_int = 16'd1;
        @(negedge clk);
        div_wr = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("bad_wr_no_pend", pending, 0);
        @(negedge clk);
        check("cfg_err_single", cfg_err, 0);
        wait_cyc(214);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_cyc(343);

        // Seven disabled cycles mid-period push the next tick out by 7.
        push(351, 0); push(366, 0); push(374, 0);
        wait_cyc(354);
        en = 1'b0;
        wait_cyc(361);
        en = 1'b1;
        wait_cyc(373);
        div_wr = 1'b1; div_int = 16'd0;
        @(negedge clk);
        div_wr = 1'b0;
        check("cfg_err_before_rst", cfg_err, 1);
        check("os_tick_before_rst", os_tick, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_os_tick", os_tick, 0);
        check("async_rst_baud_tick", baud_tick, 0);
        check("async_rst_cfg_err", cfg_err, 0);
        check("async_rst_pending", pending, 0);

        // Back to the default divisor after reset.
        @(negedge clk);
        push(4, 0); push(8, 0);
        rst = 1'b0;
        wait_cyc(8);
        en = 1'b0;
        repeat (12) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, runtime-programmable baud-rate tick generator for the UART datapath. It divides `i_clk` by a fractional divisor (integer plus `FRAC_W`-bit fraction) to produce a single-cycle oversample tick for the receiver and a 1x bit tick for the transmitter. Divisor updates are glitch-free and take effect at a period boundary. A resync input lets the receiver realign tick phase to a start-bit edge.

## Interface
- `DIV_W`, 16: width of integer divisor and period counter.
- `FRAC_W`, 4: width of fractional divisor and accumulator.
- `OVERSAMPLE`, 16: oversample ticks per baud tick; must be a power of 2, at least 2.
- `DEF_INT`, 27: active integer divisor after reset; must be at least 2.
- `DEF_FRAC`, 0: active fractional divisor after reset.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  count enable; when low, the divider freezes.
- `i_div_int`  in  DIV_W  requested integer divisor.
- `i_div_frac`  in  FRAC_W  requested fraction, in units of 1/2^FRAC_W.
- `i_div_wr`  in  1  single-cycle strobe that captures `i_div_int`/`i_div_frac`.
- `i_resync`  in  1  clears phase: period counter, accumulator and oversample counter.
- `o_os_tick`  out  1  one-cycle oversample tick (registered).
- `o_baud_tick`  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th `o_os_tick` (registered).
- `o_pending`  out  1  a captured divisor is waiting for the next period boundary.
- `o_cfg_err`  out  1  one-cycle pulse when a write is rejected.

## Operation
**State**
- `cnt` (DIV_W)
- `facc` (FRAC_W)
- `long` (1 bit): current period is int+1
- `act_int`/`act_frac`: active divisor
- `sh_int`/`sh_frac`: shadow divisor
- `pend`
- `os_cnt` (log2 OVERSAMPLE bits)

**Reset values**
- `cnt`, `facc`, `long`, `os_cnt`, `pend` all 0.
- `act` = DEF_INT/DEF_FRAC.
- Every output is 0.

**Terminal count**
- Terminal is `cnt == act_int - 1 + long`, evaluated only while `i_en`=1.

**Enabled cycle without terminal**
- `cnt` increments by 1.

**Enabled cycle with terminal**
- `cnt` <= 0 and `o_os_tick` <= 1.
- `{carry, facc}` <= `facc + act_frac`, computed in FRAC_W+1 bits; `long` <= `carry`.
- `os_cnt` increments and wraps modulo OVERSAMPLE.
- `o_baud_tick` <= 1 when `os_cnt` was OVERSAMPLE-1.
- Resulting average period is `act_int + act_frac/2^FRAC_W` cycles. Each individual period is either `act_int` or `act_int+1` cycles.

**Divisor write**
- On `i_div_wr` with `i_div_int` >= 2: shadow <= inputs and `pend` <= 1.
- On `i_div_wr` with `i_div_int` < 2: the write is ignored and `o_cfg_err` pulses on the next cycle.
- A second write while pending overwrites the shadow.

**Applying the shadow**
- While `i_en`=1, the shadow is applied at the next terminal count: `act` <= shadow, `pend` <= 0, and `facc`, `long` <= 0.
- A write in the same cycle as a terminal is applied at that terminal, using the new inputs.
- While `i_en`=0, a pending shadow is applied on the next edge, and `cnt`/`facc`/`long`/`os_cnt` are cleared.

**Disabled**
- `cnt`, `facc` and `os_cnt` hold.
- Ticks are 0 on the next edge.

**Resync**
- `i_resync`=1 sets `cnt`, `facc`, `long` and `os_cnt` to 0, and no tick is produced that cycle.
- Resync has priority over terminal count.
- Resync does not touch `pend`; a pending shadow is applied at the next terminal.

**Priority (highest first)**
1. `i_rst`
2. `i_resync`
3. pending apply while disabled
4. terminal count
5. increment

## Timing
- Ticks are registered and asserted for exactly one cycle.
- After reset deassertion, with `i_en`=1, frac=0 and divisor D: the terminal is detected at the D-th enabled edge. `o_os_tick` is high for the cycle following that edge, then every D cycles.
- After `i_resync`, the first `o_os_tick` follows D edges later.
- `o_baud_tick` period is OVERSAMPLE × the average os period.
- `o_pending` rises the cycle after `i_div_wr`. It falls the cycle after the apply edge.
- Reset mid-period is asynchronous: all state clears immediately and ticks drop the same instant.
- `cnt` never exceeds `act_int`. A divisor change never produces a truncated or extended period other than at a boundary.

## Test plan
- **Integer divisor:** DEF_INT=4, frac 0, OVERSAMPLE=16, `i_en`=1 → `o_os_tick` every 4 cycles and `o_baud_tick` every 64 cycles, coincident with the 16th os tick.
- **Fractional divisor:** write int=4, frac=8 (FRAC_W=4) → os periods alternate 4,5,4,5; 16 os ticks span exactly 72 cycles.
- **Mid-period write:** divisor 10, write 6 at cnt=3 → the current period still completes at 10 cycles, then 6-cycle periods follow. `o_pending` is high between the write and the boundary.
- **Invalid write and resync:** write int=1 → `o_cfg_err` pulses once and the period is unchanged. Assert `i_resync` at cnt=5 with D=8 → no tick, then the next tick 8 cycles later, and `os_cnt` restarts so `o_baud_tick` lands 128 cycles later.
- **Enable and reset:** deassert `i_en` for 7 cycles mid-period → no ticks and the phase is preserved on re-enable. Assert `i_rst` asynchronously mid-period → all outputs 0 immediately, and the divisor returns to DEF_INT/DEF_FRAC.
